// File: rtl/core_param_loader_if.sv
// Host word stream into the core parameter loader.
// A word moves on every rising clk edge where s_valid && s_ready; s_data is held while s_valid waits.
interface core_param_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/core_param_loader.sv
// Decodes host command headers and writes 368-bit parameter rows or neuron instructions to one core.
// Optional LOADER_CHECKSUM_EN: a PARAM row carries a 13th word holding the XOR of the 12 payload words.
module core_param_loader #(
    parameter int NUM_CORES   = 6,
    parameter int PARAM_WIDTH = 368
) (
    input  logic                   clk,
    input  logic                   reset_n,
    core_param_loader_if.slave     host,
    input  logic                   clr_err,
    output logic [NUM_CORES-1:0]   param_wen,
    output logic [PARAM_WIDTH-1:0] param_data_in,
    output logic [7:0]             param_address,
    output logic [NUM_CORES-1:0]   neuron_inst_wen,
    output logic [7:0]             neuron_inst_address,
    output logic [1:0]             neuron_inst_data_in,
    output logic                   busy,
    output logic                   load_done,
    output logic                   error,
    output logic [2:0]             dbg_state
);
    typedef enum logic [2:0] {
        ST_HEADER  = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE_P = 3'd2,
        ST_WRITE_I = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

    localparam logic [1:0] CMD_PARAM = 2'b00;
    localparam logic [1:0] CMD_INST  = 2'b01;
    localparam logic [1:0] CMD_DONE  = 2'b10;
    localparam logic [3:0] LAST_WORD = 4'd11;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [2:0]             core_q;
    logic [7:0]             addr_q;
    logic [PARAM_WIDTH-1:0] asm_q, asm_d;
    logic                   done_q, err_q;
    logic [NUM_CORES-1:0]   param_wen_q, inst_wen_q;
    logic [PARAM_WIDTH-1:0] param_data_q;
    logic [7:0]             param_addr_q, inst_addr_q;
    logic [1:0]             inst_data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]            xor_q;
`endif

    logic                 hs;
    logic [1:0]           hdr_cmd;
    logic [2:0]           hdr_core;
    logic [NUM_CORES-1:0] hdr_onehot, row_onehot;

    // Out-of-range core indices decode to all-zero, which doubles as the "bad core" test.
    function automatic logic [NUM_CORES-1:0] core_onehot(input logic [2:0] c);
        core_onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (c == 3'(i)) core_onehot[i] = 1'b1;
        end
    endfunction

    assign host.s_ready = (state_q == ST_HEADER) || (state_q == ST_COLLECT) || (state_q == ST_CHECK);
    assign hs           = host.s_valid && host.s_ready;
    assign hdr_cmd      = host.s_data[31:30];
    assign hdr_core     = host.s_data[29:27];
    assign hdr_onehot   = core_onehot(hdr_core);
    assign row_onehot   = core_onehot(core_q);

    // Row as it will look once the word on the bus this cycle is merged in.
    always_comb begin
        asm_d = asm_q;
        if (state_q == ST_COLLECT && hs) begin
            for (int k = 0; k < 11; k++) begin
                if (cnt_q == 4'(k)) asm_d[32*k +: 32] = host.s_data;
            end
            if (cnt_q == LAST_WORD) asm_d[PARAM_WIDTH-1 -: 16] = host.s_data[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HEADER;
            cnt_q        <= '0;
            core_q       <= '0;
            addr_q       <= '0;
            asm_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            param_wen_q  <= '0;
            inst_wen_q   <= '0;
            param_data_q <= '0;
            param_addr_q <= '0;
            inst_addr_q  <= '0;
            inst_data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            param_wen_q <= '0;
            inst_wen_q  <= '0;
            asm_q       <= asm_d;
            // Clear first so any set below in the same cycle takes priority.
            if (clr_err) err_q <= 1'b0;

            case (state_q)
                ST_HEADER: begin
                    if (hs) begin
                        done_q <= 1'b0;
                        case (hdr_cmd)
                            CMD_PARAM: begin
                                core_q  <= hdr_core;
                                addr_q  <= host.s_data[15:8];
                                cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                                xor_q   <= '0;
`endif
                                state_q <= ST_COLLECT;
                            end
                            CMD_INST: begin
                                state_q <= ST_WRITE_I;
                                if (|hdr_onehot) begin
                                    inst_wen_q  <= hdr_onehot;
                                    inst_addr_q <= host.s_data[15:8];
                                    inst_data_q <= host.s_data[1:0];
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            CMD_DONE: done_q <= 1'b1;
                            default:  err_q  <= 1'b1;
                        endcase
                    end
                end

                ST_COLLECT: begin
                    if (hs) begin
`ifdef LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ host.s_data;
`endif
                        if (cnt_q == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= ST_CHECK;
`else
                            state_q <= ST_WRITE_P;
                            if (|row_onehot) begin
                                param_wen_q  <= row_onehot;
                                param_data_q <= asm_d;
                                param_addr_q <= addr_q;
                            end else begin
                                err_q <= 1'b1;
                            end
`endif
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (hs) begin
                        if (host.s_data != xor_q) begin
                            err_q   <= 1'b1;
                            state_q <= ST_HEADER;
                        end else begin
                            state_q <= ST_WRITE_P;
                            if (|row_onehot) begin
                                param_wen_q  <= row_onehot;
                                param_data_q <= asm_q;
                                param_addr_q <= addr_q;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
`endif

                default: state_q <= ST_HEADER;
            endcase
        end
    end

    assign param_wen           = param_wen_q;
    assign param_data_in       = param_data_q;
    assign param_address       = param_addr_q;
    assign neuron_inst_wen     = inst_wen_q;
    assign neuron_inst_address = inst_addr_q;
    assign neuron_inst_data_in = inst_data_q;
    assign busy                = (state_q != ST_HEADER);
    assign load_done           = done_q;
    assign error               = err_q;
    assign dbg_state           = state_q;
endmodule

// File: tb/tb_core_param_loader.sv
// Directed bench for core_param_loader: write pulses are matched against an expected queue by a monitor.
module tb_core_param_loader;
    localparam int NC = 6;
    localparam int PW = 368;
    localparam int EW = 1 + NC + 8 + 2 + PW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr_err = 1'b0;
    logic [NC-1:0] param_wen, neuron_inst_wen;
    logic [PW-1:0] param_data_in;
    logic [7:0]    param_address, neuron_inst_address;
    logic [1:0]    neuron_inst_data_in;
    logic          busy, load_done, error;
    logic [2:0]    dbg_state;

    core_param_loader_if host ();

    core_param_loader #(.NUM_CORES(NC), .PARAM_WIDTH(PW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .host                (host),
        .clr_err             (clr_err),
        .param_wen           (param_wen),
        .param_data_in       (param_data_in),
        .param_address       (param_address),
        .neuron_inst_wen     (neuron_inst_wen),
        .neuron_inst_address (neuron_inst_address),
        .neuron_inst_data_in (neuron_inst_data_in),
        .busy                (busy),
        .load_done           (load_done),
        .error               (error),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    logic [31:0]   row_w [12];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] p_rec(input logic [NC-1:0] w, input logic [7:0] a, input logic [PW-1:0] d);
        return {1'b0, w, a, 2'b00, d};
    endfunction

    function automatic logic [EW-1:0] i_rec(input logic [NC-1:0] w, input logic [7:0] a, input logic [1:0] d);
        return {1'b1, w, a, d, {PW{1'b0}}};
    endfunction

    // Every write pulse must be one-hot and match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && (|param_wen || |neuron_inst_wen)) begin
            logic [EW-1:0] obs;
            check("wen_onehot", 512'($onehot({param_wen, neuron_inst_wen})), 512'd1);
            if (|param_wen) obs = p_rec(param_wen, param_address, param_data_in);
            else            obs = i_rec(neuron_inst_wen, neuron_inst_address, neuron_inst_data_in);
            if (exp_q.size() == 0) check("unexpected_write", 512'({param_wen, neuron_inst_wen}), 512'd0);
            else                   check("write", 512'(obs), 512'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        host.s_data  = d;
        host.s_valid = 1'b1;
        while (!host.s_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 512'(n < 64), 512'd1);
        @(negedge clk);
        host.s_valid = 1'b0;
    endtask

    task automatic send_row(input logic [2:0] core, input logic [7:0] addr, input int gap);
        logic [PW-1:0] d = '0;
        logic [NC-1:0] oh = 1;
        logic          busy_ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        logic [31:0]   x = '0;
`endif
        for (int k = 0; k < 11; k++) d[32*k +: 32] = row_w[k];
        d[PW-1 -: 16] = row_w[11][15:0];
        oh = oh << core;
        if (core < NC) exp_q.push_back(p_rec(oh, addr, d));
        send({2'b00, core, 11'd0, addr, 8'd0});
        for (int k = 0; k < 12; k++) begin
            repeat (gap) begin
                @(negedge clk);
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            send(row_w[k]);
`ifdef LOADER_CHECKSUM_EN
            x = x ^ row_w[k];
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        send(x);
`endif
        if (gap > 0) check("busy_in_gaps", 512'(busy_ok), 512'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a3, a;
        logic [2:0] c;
        logic [1:0] dd;
        logic [NC-1:0] oh;
        host.s_data  = '0;
        host.s_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_param_wen", 512'(param_wen), 512'd0);
        check("rst_inst_wen", 512'(neuron_inst_wen), 512'd0);
        check("rst_param_data", 512'(param_data_in), 512'd0);
        check("rst_flags", 512'({busy, load_done, error}), 512'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_state", 512'(dbg_state), 512'd0);
        check("rst_ready", 512'(host.s_ready), 512'd1);

        // Reference row: core 2, address 0x05, words 1..12.
        for (int k = 0; k < 12; k++) row_w[k] = 32'(k + 1);
        send_row(3'd2, 8'h05, 0);
        check("t1_wen", 512'(param_wen), 512'b000100);
        check("t1_addr", 512'(param_address), 512'h05);
        check("t1_lo", 512'(param_data_in[31:0]), 512'd1);
        check("t1_hi", 512'(param_data_in[367:352]), 512'h000C);
        check("t1_ready_low", 512'(host.s_ready), 512'd0);
        @(negedge clk);
        check("t1_pulse_end", 512'(param_wen), 512'd0);
        check("t1_idle", 512'(busy), 512'd0);

        // Single instruction: core 0, address 0x0A, data 3.
        exp_q.push_back(i_rec(6'b000001, 8'h0A, 2'b11));
        send(32'h4000_0A03);
        check("t2_wen", 512'(neuron_inst_wen), 512'b000001);
        check("t2_addr_data", 512'({neuron_inst_address, neuron_inst_data_in}), 512'({8'h0A, 2'b11}));
        check("t2_ready_low", 512'(host.s_ready), 512'd0);
        check("t2_param_held", 512'(param_address), 512'h05);
        @(negedge clk);
        check("t2_ready_back", 512'(host.s_ready), 512'd1);
        check("t2_pulse_end", 512'(neuron_inst_wen), 512'd0);

        // Random row with 3-cycle valid gaps.
        for (int k = 0; k < 12; k++) row_w[k] = $urandom;
        a3 = 8'($urandom_range(0, 255));
        send_row(3'd4, a3, 3);
        check("t3_wen", 512'(param_wen), 512'b010000);
        @(negedge clk);

        // Core 7 does not exist: row consumed, nothing written, error raised.
        for (int k = 0; k < 12; k++) row_w[k] = $urandom;
        send_row(3'd7, 8'h77, 0);
        check("t4_no_wen", 512'(param_wen), 512'd0);
        check("t4_error", 512'(error), 512'd1);
        check("t4_addr_held", 512'(param_address), 512'(a3));
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("t4_clr", 512'(error), 512'd0);

        // Illegal command, then DONE, then a PARAM header clears load_done.
        send(32'hC000_0000);
        check("t5_error", 512'(error), 512'd1);
        check("t5_state", 512'({dbg_state, busy}), 512'd0);
        clr_err = 1'b1;
        send(32'hC000_0000);
        clr_err = 1'b0;
        check("t5_set_wins", 512'(error), 512'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("t5_clr", 512'(error), 512'd0);
        send(32'h8000_0000);
        check("t5_done", 512'(load_done), 512'd1);
        for (int k = 0; k < 12; k++) row_w[k] = $urandom;
        send_row(3'd0, 8'hA5, 0);
        check("t5_done_cleared", 512'(load_done), 512'd0);
        @(negedge clk);

        // Reset after 6 payload words discards the row.
        send({2'b00, 3'd1, 11'd0, 8'h33, 8'd0});
        for (int k = 0; k < 6; k++) send($urandom);
        reset_n = 1'b0;
        #1;
        check("t6_wen", 512'({param_wen, neuron_inst_wen}), 512'd0);
        check("t6_data", 512'(param_data_in), 512'd0);
        check("t6_addr", 512'({param_address, neuron_inst_address, neuron_inst_data_in}), 512'd0);
        check("t6_flags", 512'({busy, load_done, error, dbg_state}), 512'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) row_w[k] = $urandom;
        send_row(3'd5, 8'h3C, 0);
        check("t6_row_after", 512'({param_wen, param_address}), 512'({6'b100000, 8'h3C}));
        @(negedge clk);

        // Back-to-back instructions to random valid cores.
        for (int i = 0; i < 5; i++) begin
            c  = 3'($urandom_range(0, NC - 1));
            a  = 8'($urandom_range(0, 255));
            dd = 2'($urandom_range(0, 3));
            oh = 1;
            oh = oh << c;
            exp_q.push_back(i_rec(oh, a, dd));
            send({2'b01, c, 11'd0, a, 6'd0, dd});
        end
        @(negedge clk);

        // Instruction to core 6 is dropped with an error.
        send({2'b01, 3'd6, 11'd0, 8'h11, 8'h02});
        check("t8_no_wen", 512'(neuron_inst_wen), 512'd0);
        check("t8_error", 512'(error), 512'd1);

        repeat (3) @(negedge clk);
        check("queue_empty", 512'(exp_q.size()), 512'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
